// File: rtl/mem_pkg.sv
// Shared definitions for the flash memory controller blocks: SPI opcodes,
// status register bit positions and the busy-poll FSM state encoding.
package mem_pkg;

    localparam logic [7:0] RDSR_OPCODE = 8'h05;

    localparam int unsigned STATUS_WIP = 0;
    localparam int unsigned STATUS_WEL = 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRsp,
        StGap,
        StDone
    } poll_state_e;

endpackage

// File: rtl/mem_interval_timer.sv
// Loadable down-counter used to space consecutive status polls.
// Load takes priority over decrement; the count stops at zero.
module mem_interval_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_wip_poll_ctrl.sv
// Sequences repeated RDSR transactions after a program/erase until the flash
// reports WIP clear, the poll budget runs out, or the caller aborts.
module mem_wip_poll_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned POLL_GAP  = 64,
    parameter int unsigned MAX_POLLS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_start,
    input  logic        in_abort,
    output logic        out_idle,
    output logic        out_done,
    output logic        out_timeout,
    output logic        out_aborted,
    output logic [7:0]  out_status,
    output logic [15:0] out_poll_count,
    output logic        spi_req_valid,
    input  logic        spi_req_ready,
    output logic [7:0]  spi_req_opcode,
    output logic [7:0]  spi_req_rd_len,
    input  logic        spi_rsp_valid,
    input  logic [7:0]  spi_rsp_data
);

    localparam int unsigned TW = $clog2(POLL_GAP) + 1;
    localparam logic [TW-1:0] GAP_LOAD = TW'(POLL_GAP - 1);
    localparam logic [15:0] MAX_POLLS_W = 16'(MAX_POLLS);

    poll_state_e state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  status_q, status_d;
    logic        timeout_q, timeout_d;
    logic        aborted_q, aborted_d;
    logic        req_valid_q, done_q, idle_q;
    logic        tmr_load, tmr_dec, tmr_zero;

    mem_interval_timer #(
        .WIDTH (TW)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (GAP_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        status_d  = status_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_start) begin
                    count_d   = '0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                // An accepted request must be seen through, so handshake beats abort.
                if (spi_req_ready) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = StWaitRsp;
                end else if (in_abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StWaitRsp: begin
                if (spi_rsp_valid) begin
                    status_d = spi_rsp_data;
                    if (!spi_rsp_data[STATUS_WIP]) begin
                        state_d = StDone;
                    end else if (count_q == MAX_POLLS_W) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end else if (in_abort) begin
                        aborted_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = StGap;
                    end
                end
            end
            StGap: begin
                if (in_abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (tmr_zero) begin
                    state_d = StIssue;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            status_q    <= '0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            status_q    <= status_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
            req_valid_q <= (state_d == StIssue);
            done_q      <= (state_d == StDone);
            idle_q      <= (state_d == StIdle);
        end
    end

    assign out_idle       = idle_q;
    assign out_done       = done_q;
    assign out_timeout    = timeout_q;
    assign out_aborted    = aborted_q;
    assign out_status     = status_q;
    assign out_poll_count = count_q;
    assign spi_req_valid  = req_valid_q;
    assign spi_req_opcode = RDSR_OPCODE;
    assign spi_req_rd_len = 8'd1;

endmodule

// File: tb/tb_mem_wip_poll_ctrl.sv
// Self-checking bench for mem_wip_poll_ctrl: directed scenarios plus randomized
// polling runs checked against a simple outcome model of the poll loop.
module tb_mem_wip_poll_ctrl;

    localparam int unsigned G    = 4;
    localparam int unsigned MAXP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic        in_abort = 1'b0;
    logic        spi_req_ready = 1'b0;
    logic        spi_rsp_valid = 1'b0;
    logic [7:0]  spi_rsp_data = 8'h00;
    logic        out_idle, out_done, out_timeout, out_aborted, spi_req_valid;
    logic [7:0]  out_status, spi_req_opcode, spi_req_rd_len;
    logic [15:0] out_poll_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] plan[$];

    mem_wip_poll_ctrl #(
        .POLL_GAP  (G),
        .MAX_POLLS (MAXP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_start       (in_start),
        .in_abort       (in_abort),
        .out_idle       (out_idle),
        .out_done       (out_done),
        .out_timeout    (out_timeout),
        .out_aborted    (out_aborted),
        .out_status     (out_status),
        .out_poll_count (out_poll_count),
        .spi_req_valid  (spi_req_valid),
        .spi_req_ready  (spi_req_ready),
        .spi_req_opcode (spi_req_opcode),
        .spi_req_rd_len (spi_req_rd_len),
        .spi_rsp_valid  (spi_rsp_valid),
        .spi_rsp_data   (spi_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watch a quiet window after a run: no request and no extra done pulse.
    task automatic watch_quiet(input string name);
        int bad = 0;
        for (int i = 0; i < int'(G) + 3; i++) begin
            tick();
            if (spi_req_valid !== 1'b0 || out_done !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL %s quiet: %0d cycles with req/done, want 0", name, bad);
        else n_pass++;
    endtask

    // One polling run; responses come from plan. Outcome per poll follows the
    // rules: WIP clear -> success, else budget spent -> timeout, else abort.
    task automatic run_poll(input string name, input int ready_dly, input int abort_at,
                            input bit watch);
        int polls = 0;
        int t;
        bit fin = 0;
        bit exp_to, exp_ab;
        logic [7:0] b;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        n_total++;
        if (spi_req_valid !== 1'b1) $display("FAIL %s start_lat: valid=%b want 1", name, spi_req_valid);
        else n_pass++;
        while (!fin) begin
            for (int i = 0; i < ready_dly; i++) begin
                n_total++;
                if (spi_req_valid !== 1'b1 || spi_req_opcode !== 8'h05 || spi_req_rd_len !== 8'd1)
                    $display("FAIL %s req_hold: valid=%b op=%h len=%0d want 1/05/1", name,
                             spi_req_valid, spi_req_opcode, spi_req_rd_len);
                else n_pass++;
                tick();
            end
            spi_req_ready = 1'b1;
            tick();
            spi_req_ready = 1'b0;
            polls++;
            n_total++;
            if (spi_req_valid !== 1'b0 || out_poll_count !== 16'(polls))
                $display("FAIL %s handshake: valid=%b count=%0d want 0/%0d", name, spi_req_valid,
                         out_poll_count, polls);
            else n_pass++;
            if (polls == abort_at) in_abort = 1'b1;
            t = (polls == abort_at) ? 3 : int'($urandom_range(0, 2));
            for (int i = 0; i < t; i++) begin
                tick();
                n_total++;
                if (out_done !== 1'b0) $display("FAIL %s early_done: done=%b want 0", name, out_done);
                else n_pass++;
            end
            b = (plan.size() != 0) ? plan.pop_front() : 8'h00;
            spi_rsp_valid = 1'b1;
            spi_rsp_data  = b;
            tick();
            spi_rsp_valid = 1'b0;
            spi_rsp_data  = 8'($urandom);
            if (!b[0] || polls == int'(MAXP) || in_abort) begin
                fin = 1;
                exp_to = b[0] && (polls == int'(MAXP));
                exp_ab = b[0] && !exp_to;
                n_total++;
                if (out_done !== 1'b1 || out_timeout !== exp_to || out_aborted !== exp_ab ||
                    out_status !== b || out_poll_count !== 16'(polls))
                    $display("FAIL %s result: done=%b to=%b ab=%b st=%h cnt=%0d want 1/%b/%b/%h/%0d",
                             name, out_done, out_timeout, out_aborted, out_status, out_poll_count,
                             exp_to, exp_ab, b, polls);
                else n_pass++;
                in_abort = 1'b0;
                tick();
                n_total++;
                if (out_idle !== 1'b1 || out_done !== 1'b0)
                    $display("FAIL %s to_idle: idle=%b done=%b want 1/0", name, out_idle, out_done);
                else n_pass++;
            end else begin
                n_total++;
                if (out_done !== 1'b0) $display("FAIL %s mid_done: done=%b want 0", name, out_done);
                else n_pass++;
                t = 0;
                while (spi_req_valid !== 1'b1 && t < int'(G) + 5) begin
                    tick();
                    t++;
                end
                n_total++;
                if (t != int'(G)) $display("FAIL %s gap: %0d cycles want %0d", name, t, G);
                else n_pass++;
                if (spi_req_valid !== 1'b1) fin = 1;
            end
        end
        if (watch) watch_quiet(name);
    endtask

    task automatic test_reset();
        n_total++;
        if (out_idle !== 1'b1 || out_done !== 1'b0 || out_timeout !== 1'b0 ||
            out_aborted !== 1'b0 || out_status !== 8'h00 || out_poll_count !== 16'd0 ||
            spi_req_valid !== 1'b0 || spi_req_opcode !== 8'h05 || spi_req_rd_len !== 8'd1)
            $display("FAIL reset: idle=%b done=%b to=%b ab=%b st=%h cnt=%0d v=%b op=%h len=%0d want 1/0/0/0/00/0/0/05/1",
                     out_idle, out_done, out_timeout, out_aborted, out_status, out_poll_count,
                     spi_req_valid, spi_req_opcode, spi_req_rd_len);
        else n_pass++;
    endtask

    task automatic test_basic();
        plan = '{8'h01, 8'h01, 8'h00};
        run_poll("basic", 0, 0, 1);
    endtask

    task automatic test_timeout();
        plan = '{8'h03, 8'h03, 8'h03};
        run_poll("timeout", 0, 0, 1);
    endtask

    task automatic test_ready_delay();
        plan = '{8'h00};
        run_poll("ready_dly", 7, 0, 1);
    endtask

    task automatic test_abort_wait();
        plan = '{8'h01};
        run_poll("abort_wait", 1, 1, 0);
        plan = '{8'h00};
        run_poll("abort_success", 0, 1, 0);
        plan = '{8'h01, 8'h01, 8'h01};
        run_poll("abort_vs_timeout", 0, 3, 1);
    endtask

    task automatic test_abort_gap();
        plan = '{};
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        spi_req_ready = 1'b1;
        tick();
        spi_req_ready = 1'b0;
        spi_rsp_valid = 1'b1;
        spi_rsp_data  = 8'h01;
        tick();
        spi_rsp_valid = 1'b0;
        tick();
        in_abort = 1'b1;
        tick();
        n_total++;
        if (out_done !== 1'b1 || out_aborted !== 1'b1 || out_timeout !== 1'b0 ||
            out_poll_count !== 16'd1 || out_status !== 8'h01)
            $display("FAIL abort_gap: done=%b ab=%b to=%b cnt=%0d st=%h want 1/1/0/1/01",
                     out_done, out_aborted, out_timeout, out_poll_count, out_status);
        else n_pass++;
        in_abort = 1'b0;
        watch_quiet("abort_gap");
    endtask

    task automatic test_abort_issue();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        tick();
        in_abort = 1'b1;
        tick();
        n_total++;
        if (out_done !== 1'b1 || out_aborted !== 1'b1 || out_poll_count !== 16'd0 ||
            spi_req_valid !== 1'b0)
            $display("FAIL abort_issue: done=%b ab=%b cnt=%0d valid=%b want 1/1/0/0",
                     out_done, out_aborted, out_poll_count, spi_req_valid);
        else n_pass++;
        in_abort = 1'b0;
        watch_quiet("abort_issue");
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        spi_req_ready = 1'b1;
        tick();
        spi_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        spi_rsp_valid = 1'b1;
        spi_rsp_data  = 8'h00;
        tick();
        spi_rsp_valid = 1'b0;
        for (int i = 0; i < int'(G) + 3; i++) begin
            if (out_idle !== 1'b1 || out_done !== 1'b0 || out_status !== 8'h00 ||
                out_poll_count !== 16'd0 || spi_req_valid !== 1'b0)
                bad++;
            tick();
        end
        n_total++;
        if (bad != 0) $display("FAIL reset_mid: %0d cycles off reset values, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        int t = 0;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        spi_req_ready = 1'b1;
        tick();
        spi_req_ready = 1'b0;
        spi_rsp_valid = 1'b1;
        spi_rsp_data  = 8'h01;
        tick();
        spi_rsp_valid = 1'b0;
        in_start = 1'b1;
        while (spi_req_valid !== 1'b1 && t < int'(G) + 5) begin
            tick();
            in_start = 1'b0;
            t++;
        end
        in_start = 1'b0;
        n_total++;
        if (t != int'(G) || out_poll_count !== 16'd1)
            $display("FAIL start_busy_gap: gap=%0d cnt=%0d want %0d/1", t, out_poll_count, G);
        else n_pass++;
        spi_req_ready = 1'b1;
        tick();
        spi_req_ready = 1'b0;
        spi_rsp_valid = 1'b1;
        spi_rsp_data  = 8'h00;
        tick();
        spi_rsp_valid = 1'b0;
        n_total++;
        if (out_done !== 1'b1 || out_poll_count !== 16'd2)
            $display("FAIL start_busy_done: done=%b cnt=%0d want 1/2", out_done, out_poll_count);
        else n_pass++;
        watch_quiet("start_busy");
    endtask

    task automatic test_back_to_back();
        plan = '{8'h00};
        run_poll("b2b_a", 0, 0, 0);
        plan = '{8'h01, 8'h80};
        run_poll("b2b_b", 1, 0, 1);
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int r = 0; r < 20; r++) begin
            plan = '{};
            for (int i = 0; i < int'(MAXP); i++) begin
                b = 8'($urandom);
                b[0] = ($urandom_range(0, 3) != 0);
                plan.push_back(b);
            end
            run_poll("random", int'($urandom_range(0, 3)), int'($urandom_range(0, MAXP)),
                     (r % 4) == 3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_timeout();
        test_ready_delay();
        test_abort_wait();
        test_abort_gap();
        test_abort_issue();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_wip_poll_ctrl.md
# mem_wip_poll_ctrl

Controller that sequences the SPI controller through flash busy-polling after a program or erase. On a start request from the transaction FSM it repeatedly issues Read Status Register (RDSR, 0x05) transactions, spaced by a programmable gap. It inspects the WIP bit of each returned status byte and reports completion or timeout. It sits between the transaction FSM and the SPI controller's command port and owns that port while busy.

## Interface
Parameters:
- POLL_GAP, default 64: idle cycles between the end of one RDSR response and the next request (≥1).
- MAX_POLLS, default 1024: RDSR attempts before timeout (1..65535).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_start  in  1  start polling; accepted only while out_idle=1
- in_abort  in  1  level; stop polling at the next safe point
- out_idle  out  1  1 = in IDLE, can accept start
- out_done  out  1  one-cycle pulse at completion (normal, timeout or abort)
- out_timeout  out  1  qualifies out_done: MAX_POLLS reached with WIP still set
- out_aborted  out  1  qualifies out_done: ended by in_abort
- out_status  out  8  last status byte received
- out_poll_count  out  16  RDSR transactions issued this run
- spi_req_valid  out  1  request to SPI controller
- spi_req_ready  in  1  SPI controller accepts request
- spi_req_opcode  out  8  constant RDSR while spi_req_valid
- spi_req_rd_len  out  8  constant 1 (one status byte)
- spi_rsp_valid  in  1  status byte valid (one-cycle pulse)
- spi_rsp_data  in  8  status byte

## Operation
- States: IDLE, ISSUE, WAIT_RSP, GAP, DONE.
- IDLE: on in_start, clear out_poll_count, out_timeout and out_aborted, then go to ISSUE. in_start outside IDLE is ignored.
- ISSUE:
  - spi_req_valid=1, held stable until spi_req_ready.
  - On handshake, out_poll_count++ and go to WAIT_RSP.
  - in_abort before the handshake: go to DONE with aborted=1, and no request is issued.
- WAIT_RSP: on spi_rsp_valid, latch out_status, then:
  - data[0]=0: go to DONE.
  - Else if out_poll_count==MAX_POLLS: go to DONE with timeout=1.
  - Else if in_abort: go to DONE with aborted=1.
  - Else go to GAP and load the gap counter with POLL_GAP-1.
  - in_abort never drops an outstanding transaction; the response is always awaited.
- GAP:
  - Gap counter decrements each cycle; at 0, go to ISSUE.
  - in_abort: go to DONE with aborted=1.
- DONE: out_done=1 for one cycle, then IDLE.
- Priority on a response: WIP clear > timeout > abort. A success that coincides with abort reports success.
- out_poll_count saturates at 0xFFFF and is held until the next start.
- Reset mid-operation: return to IDLE immediately. Any in-flight SPI response arriving after reset is ignored in IDLE.

## Timing
- Reset values: out_idle=1; all other outputs 0; spi_req_opcode=0x05 and spi_req_rd_len=1 (constants).
- in_start sampled at cycle N gives spi_req_valid=1 at N+1.
- spi_rsp_valid at M with WIP=0 gives out_done at M+1, out_idle at M+2; a new start is accepted at M+2.
- spi_rsp_valid at M with WIP=1 gives the next spi_req_valid at M+1+POLL_GAP.
- out_status, out_timeout and out_aborted are valid with out_done and hold until the next accepted start.
- All outputs are registered; no combinational path from SPI inputs to SPI outputs.

## Structure
- Shared package mem_pkg:
  - RDSR opcode 8'h05
  - status bit indices WIP=0, WEL=1
  - poll-state enum
- One sub-module: mem_interval_timer (loadable down-counter, width $clog2(POLL_GAP)+1, load/dec/zero flag). The FSM and counters stay in mem_wip_poll_ctrl.

## Test plan
- POLL_GAP=4: start; ready held 1; responses 0x01, 0x01, 0x00 → 3 requests spaced 5 cycles after each response; out_done with timeout=0, status=0x00, poll_count=3.
- MAX_POLLS=3, all responses 0x03 → out_done after the 3rd response; timeout=1, status=0x03, poll_count=3, no 4th request.
- spi_req_ready delayed 7 cycles → spi_req_valid held steady, opcode=0x05, rd_len=1 throughout; poll_count increments once.
- in_abort asserted in GAP → out_done next cycle with aborted=1 and no further request. in_abort asserted in WAIT_RSP → waits for the response, then done. Response 0x00 coinciding with abort → aborted=0.
- rst_n low during WAIT_RSP; release; spi_rsp_valid arrives → stays IDLE, outputs at reset values, no out_done.
- in_start pulsed while busy → ignored; poll_count not cleared; single out_done.
